// File: rtl/serial_display_sched.sv
// serial_display_sched
// Shares one serial shift engine between the 64-bit seven-segment chain
// (SEGLED_*) and the 16-bit LED chain (LED_*). The two requesters present
// whole frames. The arbiter serves them round-robin, shifts the granted frame
// out on that chain's CLK/DO pins, pulses the chain's latch and then acks.
//
// Optional build macro: SHIFT_LSB_FIRST_EN
//   defined   -> frames leave LSB first (bit 0 first) on both chains
//   undefined -> frames leave MSB first (bit N-1 first)
//
// Handshake: a requester raises *_req with its frame on *_data and holds both
// until the one-cycle *_ack. The frame is sampled only on the grant edge, so
// the data may change freely after that edge. A req that is still high after
// its ack counts as a fresh request and is arbitrated in the next IDLE cycle.
//
// state_dbg exposes the FSM state so that external checkers can bind to it.
module serial_display_sched #(
    parameter int CLK_DIV  = 4,
    parameter int SEG_BITS = 64,
    parameter int LED_BITS = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                seg_req,
    input  logic [SEG_BITS-1:0] seg_data,
    output logic                seg_ack,
    input  logic                led_req,
    input  logic [LED_BITS-1:0] led_data,
    output logic                led_ack,
    output logic                busy,
    output logic                SEGLED_CLK,
    output logic                SEGLED_DO,
    output logic                SEGLED_PEN,
    output logic                SEGLED_CLR,
    output logic                LED_CLK,
    output logic                LED_DO,
    output logic                LED_PEN,
    output logic                LED_CLR,
    output logic [2:0]          state_dbg
);

    localparam int         W        = (SEG_BITS > LED_BITS) ? SEG_BITS : LED_BITS;
    localparam int         CW       = $clog2(W + 1);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      div_cnt;
    logic [CW-1:0]   bit_cnt;
    logic [W-1:0]    sr;
    logic            sel_led;   // chain being served: 1 = LED, 0 = segment
    logic            last_led;  // chain served last: 1 = LED, 0 = segment
    logic            clr_q;
    logic            div_end;
    logic            last_bit;
    logic            grant;
    logic            grant_led;
    logic            cur_bit;
    logic            do_v;
    logic            clk_v;
    logic            pen_v;
    logic            done_v;

    // Arbitration: a lone request wins; on a tie the chain not served last wins.
    always_comb begin
        grant     = (state_q == IDLE) && clr_q && (seg_req || led_req);
        grant_led = led_req && (!seg_req || !last_led);
        div_end   = (div_cnt == DIV_LAST);
        last_bit  = (bit_cnt == CW'(1));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (grant) state_d = SHIFT_LO;
            SHIFT_LO: if (div_end) state_d = SHIFT_HI;
            SHIFT_HI: if (div_end) state_d = last_bit ? LATCH : SHIFT_LO;
            LATCH:    if (div_end) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath: frame capture, shifting, phase and bit counters, served-chain flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            sel_led  <= 1'b0;
            last_led <= 1'b1;
            clr_q    <= 1'b0;
        end else begin
            clr_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    div_cnt <= '0;
                    if (grant) begin
                        sel_led <= grant_led;
`ifdef SHIFT_LSB_FIRST_EN
                        sr <= grant_led ? W'(led_data) : W'(seg_data);
`else
                        // Left-align the frame so its MSB sits at the output end.
                        sr <= grant_led ? (W'(led_data) << (W - LED_BITS))
                                        : (W'(seg_data) << (W - SEG_BITS));
`endif
                        bit_cnt <= grant_led ? CW'(LED_BITS) : CW'(SEG_BITS);
                    end
                end
                SHIFT_LO, LATCH: begin
                    div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
                end
                SHIFT_HI: begin
                    div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
                    if (div_end) begin
`ifdef SHIFT_LSB_FIRST_EN
                        sr <= {1'b0, sr[W-1:1]};
`else
                        sr <= {sr[W-2:0], 1'b0};
`endif
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                DONE: begin
                    div_cnt  <= '0;
                    last_led <= sel_led;
                end
                default: div_cnt <= '0;
            endcase
        end
    end

    // Pin drive: only the selected chain toggles; the other chain stays at 0.
    always_comb begin
`ifdef SHIFT_LSB_FIRST_EN
        cur_bit = sr[0];
`else
        cur_bit = sr[W-1];
`endif
        do_v       = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && cur_bit;
        clk_v      = (state_q == SHIFT_HI);
        pen_v      = (state_q == LATCH);
        done_v     = (state_q == DONE);
        SEGLED_CLK = clk_v  && !sel_led;
        SEGLED_DO  = do_v   && !sel_led;
        SEGLED_PEN = pen_v  && !sel_led;
        seg_ack    = done_v && !sel_led;
        LED_CLK    = clk_v  && sel_led;
        LED_DO     = do_v   && sel_led;
        LED_PEN    = pen_v  && sel_led;
        led_ack    = done_v && sel_led;
        SEGLED_CLR = clr_q;
        LED_CLR    = clr_q;
        busy       = (state_q != IDLE);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_serial_display_sched.sv
// Bench for serial_display_sched with CLK_DIV=2.
// A reference model derives each expected bit stream, its latency and its
// latch width from the frame data and the chain length. Every scenario task
// compares the captured pin activity against that model.
module tb_serial_display_sched;

    localparam int D  = 2;
    localparam int SB = 64;
    localparam int LB = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          seg_req;
    logic [SB-1:0] seg_data;
    logic          seg_ack;
    logic          led_req;
    logic [LB-1:0] led_data;
    logic          led_ack;
    logic          busy;
    logic          SEGLED_CLK, SEGLED_DO, SEGLED_PEN, SEGLED_CLR;
    logic          LED_CLK, LED_DO, LED_PEN, LED_CLR;
    logic [2:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [0:0] exp_q[$];

    // Results of the most recent captured frame.
    int   cap_grant, cap_ack, cap_pen;
    logic cap_ack_seg, cap_ack_led, cap_seg_act, cap_led_act;
    logic cap_ack_after, cap_busy_after, cap_timeout;
    logic cap_seg_bits[$];
    logic cap_led_bits[$];

    serial_display_sched #(.CLK_DIV(D), .SEG_BITS(SB), .LED_BITS(LB)) dut (
        .clk(clk), .rstn(rstn),
        .seg_req(seg_req), .seg_data(seg_data), .seg_ack(seg_ack),
        .led_req(led_req), .led_data(led_data), .led_ack(led_ack),
        .busy(busy),
        .SEGLED_CLK(SEGLED_CLK), .SEGLED_DO(SEGLED_DO), .SEGLED_PEN(SEGLED_PEN), .SEGLED_CLR(SEGLED_CLR),
        .LED_CLK(LED_CLK), .LED_DO(LED_DO), .LED_PEN(LED_PEN), .LED_CLR(LED_CLR),
        .state_dbg(state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Reference model: expected serial order of a frame.
    function automatic void build_exp(input logic [63:0] data, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
`ifdef SHIFT_LSB_FIRST_EN
            exp_q.push_back(data[i]);
`else
            exp_q.push_back(data[n-1-i]);
`endif
        end
    endfunction

    function automatic int exp_latency(input int n);
        return n * 2 * D + D;
    endfunction

    task automatic do_reset();
        rstn    = 1'b0;
        seg_req = 1'b0;
        led_req = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Driver/monitor: waits for a grant, records both chains until an ack,
    // drops the requests in drop_mask ({seg,led}) in the ack cycle, then samples
    // the following cycle.
    task automatic capture(input logic [1:0] drop_mask, input bit scramble);
        bit prev_sc, prev_lc;
        int budget;
        cap_seg_bits.delete();
        cap_led_bits.delete();
        cap_pen = 0; cap_seg_act = 0; cap_led_act = 0;
        cap_ack_seg = 0; cap_ack_led = 0; cap_ack_after = 0; cap_busy_after = 0;
        cap_timeout = 0; cap_grant = 0; cap_ack = 0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!busy && budget < 2000);
        if (!busy) begin
            cap_timeout = 1;
            return;
        end
        cap_grant = cyc;
        prev_sc = 0; prev_lc = 0;
        budget = 0;
        forever begin
            if (SEGLED_CLK && !prev_sc) cap_seg_bits.push_back(SEGLED_DO);
            if (LED_CLK && !prev_lc) cap_led_bits.push_back(LED_DO);
            prev_sc = SEGLED_CLK;
            prev_lc = LED_CLK;
            if (SEGLED_CLK || SEGLED_DO || SEGLED_PEN) cap_seg_act = 1;
            if (LED_CLK || LED_DO || LED_PEN) cap_led_act = 1;
            if (SEGLED_PEN || LED_PEN) cap_pen++;
            if (seg_ack || led_ack) break;
            budget++;
            if (budget > 3000) begin
                cap_timeout = 1;
                return;
            end
            if (scramble) begin
                seg_data = {$urandom, $urandom};
                led_data = 16'($urandom);
            end
            @(negedge clk);
        end
        cap_ack     = cyc;
        cap_ack_seg = seg_ack;
        cap_ack_led = led_ack;
        if (drop_mask[1]) seg_req = 1'b0;
        if (drop_mask[0]) led_req = 1'b0;
        @(negedge clk);
        cap_ack_after  = seg_ack || led_ack;
        cap_busy_after = busy;
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        rstn = 1'b0; seg_req = 1'b0; led_req = 1'b0;
        seg_data = '0; led_data = '0;
        repeat (2) @(negedge clk);
        outs = {SEGLED_CLK, SEGLED_DO, SEGLED_PEN, SEGLED_CLR, LED_CLK, LED_DO, LED_PEN, LED_CLR,
                seg_ack, led_ack, busy};
        n_checks++;
        if (outs !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 11'b0);
        end
        led_req = 1'b1;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({SEGLED_CLR, LED_CLR} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_clr_release: got %b expected 11", {SEGLED_CLR, LED_CLR});
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_first_grant: busy got %b expected 0", busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_second_edge_grant: busy got %b expected 1", busy);
        end
    endtask

    task automatic test_led_frame();
        logic [15:0] tbl;
`ifdef SHIFT_LSB_FIRST_EN
        tbl = 16'b1100_0011_1010_0101;
`else
        tbl = 16'b1010_0101_1100_0011;
`endif
        do_reset();
        led_data = 16'hA5C3;
        build_exp(64'(led_data), LB);
        led_req = 1'b1;
        capture(2'b01, 1'b0);
        n_checks++;
        if (cap_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL led_timeout: got %b expected 0", cap_timeout);
        end
        n_checks++;
        if (cap_led_bits.size() != LB) begin
            n_fail++;
            $display("FAIL led_rises: got %0d expected %0d", cap_led_bits.size(), LB);
        end
        for (int i = 0; i < LB; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (i >= cap_led_bits.size() || cap_led_bits[i] !== e || cap_led_bits[i] !== tbl[15-i]) begin
                n_fail++;
                $display("FAIL led_bit[%0d]: got %b expected %b", i,
                         (i < cap_led_bits.size()) ? cap_led_bits[i] : 1'bx, e);
            end
        end
        n_checks++;
        if (cap_seg_act !== 1'b0 || cap_seg_bits.size() != 0) begin
            n_fail++;
            $display("FAIL led_seg_idle: got activity %b rises %0d expected 0 0", cap_seg_act, cap_seg_bits.size());
        end
        n_checks++;
        if (cap_ack - cap_grant != 66 || cap_ack - cap_grant != exp_latency(LB)) begin
            n_fail++;
            $display("FAIL led_latency: got %0d expected %0d", cap_ack - cap_grant, 66);
        end
        n_checks++;
        if ({cap_ack_led, cap_ack_seg} !== 2'b10) begin
            n_fail++;
            $display("FAIL led_ack_chain: got led=%b seg=%b expected led=1 seg=0", cap_ack_led, cap_ack_seg);
        end
        n_checks++;
        if (cap_pen != D) begin
            n_fail++;
            $display("FAIL led_pen_width: got %0d expected %0d", cap_pen, D);
        end
        n_checks++;
        if ({cap_ack_after, cap_busy_after} !== 2'b00) begin
            n_fail++;
            $display("FAIL led_ack_one_cycle: got ack=%b busy=%b expected 0 0", cap_ack_after, cap_busy_after);
        end
    endtask

    task automatic test_seg_frame();
        do_reset();
        seg_data = 64'h0123_4567_89AB_CDEF;
        build_exp(seg_data, SB);
        seg_req = 1'b1;
        capture(2'b10, 1'b0);
        n_checks++;
        if (cap_seg_bits.size() != SB || cap_timeout) begin
            n_fail++;
            $display("FAIL seg_rises: got %0d expected %0d (timeout %b)", cap_seg_bits.size(), SB, cap_timeout);
        end
        for (int i = 0; i < SB; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (i >= cap_seg_bits.size() || cap_seg_bits[i] !== e) begin
                n_fail++;
                $display("FAIL seg_bit[%0d]: got %b expected %b", i,
                         (i < cap_seg_bits.size()) ? cap_seg_bits[i] : 1'bx, e);
            end
        end
        n_checks++;
        if (cap_ack - cap_grant != 258 || cap_ack - cap_grant != exp_latency(SB)) begin
            n_fail++;
            $display("FAIL seg_latency: got %0d expected %0d", cap_ack - cap_grant, 258);
        end
        n_checks++;
        if (cap_pen != 2) begin
            n_fail++;
            $display("FAIL seg_pen_width: got %0d expected 2", cap_pen);
        end
        n_checks++;
        if (cap_led_act !== 1'b0 || {cap_ack_seg, cap_ack_led} !== 2'b10) begin
            n_fail++;
            $display("FAIL seg_chain_select: got led_act=%b ack seg=%b led=%b expected 0 1 0",
                     cap_led_act, cap_ack_seg, cap_ack_led);
        end
    endtask

    task automatic test_tie();
        int first_ack;
        do_reset();
        seg_data = {$urandom, $urandom};
        led_data = 16'($urandom);
        @(negedge clk);
        seg_req = 1'b1;
        led_req = 1'b1;
        build_exp(seg_data, SB);
        capture(2'b10, 1'b0);
        first_ack = cap_ack;
        n_checks++;
        if ({cap_ack_seg, cap_ack_led} !== 2'b10 || cap_seg_bits.size() != SB) begin
            n_fail++;
            $display("FAIL tie_first_seg: got ack seg=%b led=%b rises %0d expected 1 0 %0d",
                     cap_ack_seg, cap_ack_led, cap_seg_bits.size(), SB);
        end
        for (int i = 0; i < SB && i < cap_seg_bits.size(); i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (cap_seg_bits[i] !== e) begin
                n_fail++;
                $display("FAIL tie_seg_bit[%0d]: got %b expected %b", i, cap_seg_bits[i], e);
            end
        end
        n_checks++;
        if (cap_busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_idle_gap: busy got %b expected 0", cap_busy_after);
        end
        build_exp(64'(led_data), LB);
        capture(2'b01, 1'b0);
        n_checks++;
        if ({cap_ack_seg, cap_ack_led} !== 2'b01 || cap_led_bits.size() != LB) begin
            n_fail++;
            $display("FAIL tie_second_led: got ack seg=%b led=%b rises %0d expected 0 1 %0d",
                     cap_ack_seg, cap_ack_led, cap_led_bits.size(), LB);
        end
        for (int i = 0; i < LB && i < cap_led_bits.size(); i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (cap_led_bits[i] !== e) begin
                n_fail++;
                $display("FAIL tie_led_bit[%0d]: got %b expected %b", i, cap_led_bits[i], e);
            end
        end
        n_checks++;
        if (cap_grant != first_ack + 2) begin
            n_fail++;
            $display("FAIL tie_regrant_time: got %0d expected %0d", cap_grant, first_ack + 2);
        end
    endtask

    task automatic test_fairness();
        int  prev_ack;
        bit  want_seg;
        do_reset();
        seg_data = {$urandom, $urandom};
        led_data = 16'($urandom);
        @(negedge clk);
        seg_req = 1'b1;
        led_req = 1'b1;
        prev_ack = 0;
        for (int k = 0; k < 6; k++) begin
            want_seg = (k % 2 == 0);
            capture((k == 5) ? 2'b11 : 2'b00, 1'b0);
            n_checks++;
            if ({cap_ack_seg, cap_ack_led} !== {want_seg, !want_seg} || cap_timeout) begin
                n_fail++;
                $display("FAIL fair_grant[%0d]: got ack seg=%b led=%b expected seg=%b led=%b",
                         k, cap_ack_seg, cap_ack_led, want_seg, !want_seg);
            end
            n_checks++;
            if (cap_ack - cap_grant != exp_latency(want_seg ? SB : LB)) begin
                n_fail++;
                $display("FAIL fair_latency[%0d]: got %0d expected %0d", k, cap_ack - cap_grant,
                         exp_latency(want_seg ? SB : LB));
            end
            if (k > 0) begin
                n_checks++;
                if (cap_grant != prev_ack + 2) begin
                    n_fail++;
                    $display("FAIL fair_back_to_back[%0d]: got grant %0d expected %0d", k, cap_grant, prev_ack + 2);
                end
            end
            prev_ack = cap_ack;
        end
        n_checks++;
        if (cap_busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_end_idle: busy got %b expected 0", cap_busy_after);
        end
    endtask

    task automatic test_random();
        bit use_seg;
        int n;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            use_seg = ($urandom_range(0, 1) == 1);
            n = use_seg ? SB : LB;
            seg_data = {$urandom, $urandom};
            led_data = 16'($urandom);
            build_exp(use_seg ? seg_data : 64'(led_data), n);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (use_seg) seg_req = 1'b1;
            else         led_req = 1'b1;
            capture(use_seg ? 2'b10 : 2'b01, 1'b1);
            n_checks++;
            if ((use_seg ? cap_seg_bits.size() : cap_led_bits.size()) != n || cap_timeout) begin
                n_fail++;
                $display("FAIL rand_rises[%0d]: got %0d expected %0d", k,
                         use_seg ? cap_seg_bits.size() : cap_led_bits.size(), n);
            end
            for (int i = 0; i < n; i++) begin
                logic e, g;
                e = exp_q.pop_front();
                if (use_seg) g = (i < cap_seg_bits.size()) ? cap_seg_bits[i] : 1'bx;
                else         g = (i < cap_led_bits.size()) ? cap_led_bits[i] : 1'bx;
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL rand_bit[%0d][%0d]: got %b expected %b", k, i, g, e);
                end
            end
            n_checks++;
            if (cap_ack - cap_grant != exp_latency(n) || (use_seg ? cap_led_act : cap_seg_act)) begin
                n_fail++;
                $display("FAIL rand_frame[%0d]: latency got %0d expected %0d, other chain active %b expected 0",
                         k, cap_ack - cap_grant, exp_latency(n), use_seg ? cap_led_act : cap_seg_act);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] outs;
        int rel;
        int budget;
        bit saw_ack;
        do_reset();
        led_data = 16'hA5C3;
        led_req = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!busy && budget < 100);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        outs = {SEGLED_CLK, SEGLED_DO, SEGLED_PEN, SEGLED_CLR, LED_CLK, LED_DO, LED_PEN, LED_CLR,
                seg_ack, led_ack, busy};
        n_checks++;
        if (outs !== 11'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b expected %b", outs, 11'b0);
        end
        saw_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (led_ack || seg_ack || busy) saw_ack = 1;
        end
        n_checks++;
        if (saw_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_held: got activity %b expected 0", saw_ack);
        end
        rstn = 1'b1;
        rel = cyc;
        @(negedge clk);
        n_checks++;
        if ({SEGLED_CLR, LED_CLR, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL mid_reset_release: got clr=%b%b busy=%b expected 11 0", SEGLED_CLR, LED_CLR, busy);
        end
        build_exp(64'(led_data), LB);
        capture(2'b01, 1'b0);
        n_checks++;
        if (cap_grant != rel + 2 || cap_ack - cap_grant != exp_latency(LB) || !cap_ack_led) begin
            n_fail++;
            $display("FAIL mid_reset_rerequest: got grant %0d latency %0d ack %b expected %0d %0d 1",
                     cap_grant, cap_ack - cap_grant, cap_ack_led, rel + 2, exp_latency(LB));
        end
        n_checks++;
        if (cap_led_bits.size() != LB) begin
            n_fail++;
            $display("FAIL mid_reset_rises: got %0d expected %0d", cap_led_bits.size(), LB);
        end
        for (int i = 0; i < LB && i < cap_led_bits.size(); i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (cap_led_bits[i] !== e) begin
                n_fail++;
                $display("FAIL mid_reset_bit[%0d]: got %b expected %b", i, cap_led_bits[i], e);
            end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_led_frame();
        test_seg_frame();
        test_tie();
        test_fairness();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
